kbd_link_rx: RTL and testbench

- Receives keyboard and joystick state from the board MCU over a 3-wire serial link (SPI mode 0, MCU is master).
- Holds an 8-row by 5-column key matrix and the Kempston byte.
- Presents the Spectrum-style half-row read data (kd) and kempston_data to the port decoder, i.e. it is the producing end of those signals.
- Also generates the magic-button request pulse and releases all keys when the link goes silent.

---
 rtl/kbd_link_rx_pkg.sv | 22 ++
 rtl/kbd_link_rx_sync_edge.sv | 41 ++++
 rtl/kbd_link_rx.sv | 180 ++++++++++++++++++
 tb/tb_kbd_link_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_link_rx_pkg.sv
// kbd_link_rx_pkg
//   Shared definitions for the MCU keyboard/joystick link receiver:
//   link command codes and the receiver FSM state type.
package kbd_link_rx_pkg;

  localparam logic [7:0] LINK_CMD_ROW_BASE = 8'h00;
  localparam logic [7:0] LINK_CMD_KEMPSTON = 8'h08;
  localparam logic [7:0] LINK_CMD_MAGIC    = 8'h09;
  localparam logic [7:0] LINK_CMD_CLEAR    = 8'h0F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } link_state_t;

  // Row commands occupy 0x00-0x07; the low three bits select the row.
  function automatic logic is_row_cmd(input logic [7:0] cmd);
    return cmd[7:3] == LINK_CMD_ROW_BASE[7:3];
  endfunction

endpackage

// File: rtl/kbd_link_rx_sync_edge.sv
// kbd_link_rx_sync_edge
//   Multi-flop synchronizer for one asynchronous input, plus a single-edge
//   detector on the synchronized level.
//   clk28     in   system clock
//   rst_n     in   asynchronous active-low reset
//   i_async   in   asynchronous input
//   o_sync    out  synchronized level
//   o_edge    out  one-cycle pulse on a rising (RISE=1) or falling (RISE=0) edge
module kbd_link_rx_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0,
  parameter logic        RISE      = 1'b1
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_edge
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic [STAGES:0]   w_chain;

  assign w_chain = {r_sync, i_async};

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= w_chain[STAGES-1:0];
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_edge = RISE ? (r_sync[STAGES-1] & ~r_prev)
                       : (~r_sync[STAGES-1] & r_prev);

endmodule

// File: rtl/kbd_link_rx.sv
// kbd_link_rx
//   Receives key matrix and joystick state from the board MCU over a
//   3-wire SPI mode-0 link (MCU is master, 16-bit frames: cmd, dat).
//   clk28          in   system clock, 28 MHz
//   rst_n          in   asynchronous active-low reset
//   bus_a[15:8]    in   CPU address high byte, half-row select, active-low
//   mcu_sck        in   link clock (asynchronous)
//   mcu_mosi       in   link data, MSB first
//   mcu_cs_n       in   frame select, active-low
//   kd             out  half-row key data, active-low, registered
//   kempston_data  out  joystick byte, active-high
//   magic_button   out  one-cycle magic-button request
//   link_ok        out  high while the link watchdog has not expired
module kbd_link_rx
  import kbd_link_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_W   = 22,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic [15:8] bus_a,
  input  logic        mcu_sck,
  input  logic        mcu_mosi,
  input  logic        mcu_cs_n,
  output logic [4:0]  kd,
  output logic [7:0]  kempston_data,
  output logic        magic_button,
  output logic        link_ok
);

  logic w_sck_rise;
  logic w_unused_sck_level;
  logic w_cs_n;
  logic w_cs_fall;
  logic w_mosi;
  logic w_unused_mosi_edge;

  kbd_link_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .RISE(1'b1)) u_sync_sck (
    .clk28   (clk28),
    .rst_n   (rst_n),
    .i_async (mcu_sck),
    .o_sync  (w_unused_sck_level),
    .o_edge  (w_sck_rise)
  );

  kbd_link_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .RISE(1'b0)) u_sync_cs (
    .clk28   (clk28),
    .rst_n   (rst_n),
    .i_async (mcu_cs_n),
    .o_sync  (w_cs_n),
    .o_edge  (w_cs_fall)
  );

  kbd_link_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .RISE(1'b1)) u_sync_mosi (
    .clk28   (clk28),
    .rst_n   (rst_n),
    .i_async (mcu_mosi),
    .o_sync  (w_mosi),
    .o_edge  (w_unused_mosi_edge)
  );

  // Shift register and bit counter
  logic [15:0] r_shreg;
  logic [3:0]  r_bitcnt;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else if (w_cs_n) begin
      r_bitcnt <= '0;
    end else if (w_sck_rise) begin
      r_shreg  <= {r_shreg[14:0], w_mosi};
      r_bitcnt <= r_bitcnt + 4'd1;
    end
  end

  // Receiver FSM
  link_state_t r_state;
  link_state_t w_state_nxt;
  logic        w_commit;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        // cs_n rising before the 16th bit drops the partial frame
        if (w_cs_n)                                w_state_nxt = IDLE;
        else if (w_sck_rise && r_bitcnt == 4'd15)  w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = w_cs_n ? IDLE : SHIFT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame decode and watchdog
  logic [7:0]          w_cmd;
  logic [7:0]          w_dat;
  logic                w_expired;
  logic [7:0][4:0]     r_rows;
  logic [7:0]          r_kemp;
  logic                r_magic;
  logic                r_link_ok;
  logic [TIMEOUT_W-1:0] r_wdog;

  assign w_cmd     = r_shreg[15:8];
  assign w_dat     = r_shreg[7:0];
  assign w_expired = &r_wdog;

  // A commit takes priority over watchdog saturation in the same cycle.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_rows    <= '0;
      r_kemp    <= '0;
      r_magic   <= 1'b0;
      r_link_ok <= 1'b0;
      r_wdog    <= '0;
    end else begin
      r_magic <= 1'b0;
      if (w_commit) begin
        r_wdog    <= '0;
        r_link_ok <= 1'b1;
        if (is_row_cmd(w_cmd)) begin
          r_rows[w_cmd[2:0]] <= w_dat[4:0];
        end else begin
          case (w_cmd)
            LINK_CMD_KEMPSTON: r_kemp  <= w_dat;
            LINK_CMD_MAGIC:    r_magic <= w_dat[0];
            LINK_CMD_CLEAR: begin
              r_rows <= '0;
              r_kemp <= '0;
            end
            default: ;
          endcase
        end
      end else if (w_expired) begin
        r_rows    <= '0;
        r_kemp    <= '0;
        r_link_ok <= 1'b0;
      end else begin
        r_wdog <= r_wdog + TIMEOUT_W'(1);
      end
    end
  end

  // Half-row read: OR every row whose address line is low, then invert.
  logic [4:0] w_sel;
  logic [4:0] r_kd;

  always_comb begin
    w_sel = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      if (!bus_a[8+n]) w_sel = w_sel | r_rows[n];
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) r_kd <= '1;
    else        r_kd <= ~w_sel;
  end

  assign kd            = r_kd;
  assign kempston_data = r_kemp;
  assign magic_button  = r_magic;
  assign link_ok       = r_link_ok;

endmodule

// File: tb/tb_kbd_link_rx.sv
// tb_kbd_link_rx
//   Directed bench for kbd_link_rx: a table of single-frame vectors plus
//   hand-written sequences for latency, partial frames, back-to-back
//   frames, mid-frame reset and watchdog expiry (second instance, TIMEOUT_W=8).
module tb_kbd_link_rx;

  logic       clk28    = 1'b0;
  logic       rst_n    = 1'b0;
  logic       mcu_sck  = 1'b0;
  logic       mcu_mosi = 1'b0;
  logic       mcu_cs_n = 1'b1;
  logic [7:0] a_hi     = 8'hFF;

  logic [4:0] kd, kd_wd;
  logic [7:0] kemp, kemp_wd;
  logic       magic, magic_wd, link_ok, link_ok_wd;

  int n_cmp   = 0;
  int n_fail  = 0;
  int mag_cnt = 0;

  always #18 clk28 = ~clk28;

  kbd_link_rx dut (
    .clk28         (clk28),
    .rst_n         (rst_n),
    .bus_a         (a_hi),
    .mcu_sck       (mcu_sck),
    .mcu_mosi      (mcu_mosi),
    .mcu_cs_n      (mcu_cs_n),
    .kd            (kd),
    .kempston_data (kemp),
    .magic_button  (magic),
    .link_ok       (link_ok)
  );

  kbd_link_rx #(.TIMEOUT_W(8)) dut_wd (
    .clk28         (clk28),
    .rst_n         (rst_n),
    .bus_a         (a_hi),
    .mcu_sck       (mcu_sck),
    .mcu_mosi      (mcu_mosi),
    .mcu_cs_n      (mcu_cs_n),
    .kd            (kd_wd),
    .kempston_data (kemp_wd),
    .magic_button  (magic_wd),
    .link_ok       (link_ok_wd)
  );

  always @(negedge clk28) if (magic) mag_cnt++;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [7:0] a;
    logic [4:0] kd;
    logic [7:0] kemp;
    int         magic;
  } vec_t;

  localparam int NV = 12;
  vec_t vt[NV];

  task automatic tick(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      mcu_mosi = data[i];
      tick(4);
      mcu_sck = 1'b1;
      tick(4);
      mcu_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    mcu_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    mcu_cs_n = 1'b1;
    tick(4);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] dat);
    cs_low();
    shift_bits({16'h0000, cmd, dat}, 16);
    cs_high();
  endtask

  initial begin
    int m0;

    vt[0]  = '{8'h00, 8'h01, 8'hFE, 5'b11110, 8'h00, 0};
    vt[1]  = '{8'h07, 8'h10, 8'h7E, 5'b01110, 8'h00, 0};
    vt[2]  = '{8'h20, 8'hFF, 8'hFF, 5'b11111, 8'h00, 0};
    vt[3]  = '{8'h08, 8'h15, 8'h7E, 5'b01110, 8'h15, 0};
    vt[4]  = '{8'h09, 8'h01, 8'h7E, 5'b01110, 8'h15, 1};
    vt[5]  = '{8'h09, 8'h00, 8'hFE, 5'b11110, 8'h15, 0};
    vt[6]  = '{8'h03, 8'hEA, 8'hF7, 5'b10101, 8'h15, 0};
    vt[7]  = '{8'h02, 8'hE3, 8'hF3, 5'b10100, 8'h15, 0};
    vt[8]  = '{8'h0F, 8'h00, 8'h00, 5'b11111, 8'h00, 0};
    vt[9]  = '{8'h05, 8'h1F, 8'hDF, 5'b00000, 8'h00, 0};
    vt[10] = '{8'h08, 8'hAA, 8'hFD, 5'b11111, 8'hAA, 0};
    vt[11] = '{8'h01, 8'h04, 8'hFD, 5'b11011, 8'hAA, 0};

    // Reset state
    tick(3);
    chk("rst_kd", kd, 5'b11111);
    chk("rst_kemp", kemp, 8'h00);
    chk("rst_magic", magic, 1'b0);
    chk("rst_link_ok", link_ok, 1'b0);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_link_ok", link_ok, 1'b0);

    // Table-driven single frames
    for (int i = 0; i < NV; i++) begin
      m0 = mag_cnt;
      send_frame(vt[i].cmd, vt[i].dat);
      a_hi = vt[i].a;
      tick(2);
      chk($sformatf("v%0d_kd", i), kd, vt[i].kd);
      chk($sformatf("v%0d_kemp", i), kemp, vt[i].kemp);
      chk($sformatf("v%0d_magic_cnt", i), mag_cnt - m0, vt[i].magic);
      chk($sformatf("v%0d_link_ok", i), link_ok, 1'b1);
    end

    // kd follows the address with one cycle of latency
    a_hi = 8'hDF;
    tick(1);
    chk("addr_lat_row5", kd, 5'b00000);
    a_hi = 8'hFF;
    tick(1);
    chk("addr_lat_ff", kd, 5'b11111);

    // Last sck rise to kd within SYNC_STAGES + 3 cycles
    send_frame(8'h0F, 8'h00);
    a_hi = 8'hFE;
    cs_low();
    shift_bits(32'h0000_0001, 15);
    mcu_mosi = 1'b0;
    tick(4);
    mcu_sck = 1'b1;
    tick(5);
    chk("latency_kd", kd, 5'b11101);
    mcu_sck = 1'b0;
    cs_high();

    // Partial frame is discarded; next frame decodes normally
    send_frame(8'h08, 8'h5A);
    cs_low();
    shift_bits(32'h0000_0011, 9);
    cs_high();
    tick(4);
    chk("partial_kemp", kemp, 8'h5A);
    chk("partial_kd", kd, 5'b11101);
    send_frame(8'h08, 8'h03);
    tick(2);
    chk("after_partial_kemp", kemp, 8'h03);

    // Two frames under one cs_n assertion
    cs_low();
    shift_bits(32'h021F_0880, 32);
    cs_high();
    a_hi = 8'hFB;
    tick(2);
    chk("b2b_row2_kd", kd, 5'b00000);
    chk("b2b_kemp", kemp, 8'h80);

    // Watchdog expiry on the short-timeout instance
    send_frame(8'h00, 8'h1F);
    a_hi = 8'hFE;
    tick(2);
    chk("wd_pre_kd", kd_wd, 5'b00000);
    chk("wd_pre_link_ok", link_ok_wd, 1'b1);
    tick(300);
    chk("wd_exp_kd", kd_wd, 5'b11111);
    chk("wd_exp_kemp", kemp_wd, 8'h00);
    chk("wd_exp_link_ok", link_ok_wd, 1'b0);
    chk("main_kd_held", kd, 5'b00000);
    chk("main_link_ok_held", link_ok, 1'b1);
    send_frame(8'h20, 8'h00);
    tick(2);
    chk("wd_restore_link_ok", link_ok_wd, 1'b1);
    chk("wd_restore_kd", kd_wd, 5'b11111);

    // Reset in the middle of a frame discards it
    cs_low();
    shift_bits(32'h0000_0008, 8);
    rst_n = 1'b0;
    tick(2);
    chk("midrst_kemp", kemp, 8'h00);
    rst_n = 1'b1;
    shift_bits(32'h0000_00FF, 8);
    cs_high();
    tick(2);
    chk("midrst_after_kemp", kemp, 8'h00);
    chk("midrst_link_ok", link_ok, 1'b0);
    send_frame(8'h08, 8'h42);
    tick(2);
    chk("midrst_next_kemp", kemp, 8'h42);
    chk("midrst_next_link_ok", link_ok, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
